// File: rtl/lpc_regbank_pkg.sv
//------------------------------------------------------------------------------
// Module      : lpc_regbank_pkg
// Description : Shared types and default sizing for the LPC register bank.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lpc_regbank_pkg;

    localparam int LPC_DATA_W = 32;
    localparam int LPC_DEPTH  = 9;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } lpc_state_t;

endpackage : lpc_regbank_pkg

`default_nettype wire

// File: rtl/lpc_regbank_if.sv
//------------------------------------------------------------------------------
// Module      : lpc_regbank_if
// Description : Write/read/stream signal bundle for lpc_regbank.
//               LPC_REGBANK_REVERSE_EN adds the stream_rev control.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lpc_regbank_if
    import lpc_regbank_pkg::*;
#(
    parameter int DATA_W = LPC_DATA_W,
    parameter int DEPTH  = LPC_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) ();

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              shift_en;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              stream_start;
    logic              stream_valid;
    logic              stream_ready;
    logic [DATA_W-1:0] stream_data;
    logic [ADDR_W-1:0] stream_idx;
    logic              stream_last;
    logic              busy;
`ifdef LPC_REGBANK_REVERSE_EN
    logic              stream_rev;
`endif

    modport master (
`ifdef LPC_REGBANK_REVERSE_EN
        output stream_rev,
`endif
        output wr_en, wr_addr, shift_en, din, rd_addr, stream_start, stream_ready,
        input  rd_data, stream_valid, stream_data, stream_idx, stream_last, busy
    );

    modport slave (
`ifdef LPC_REGBANK_REVERSE_EN
        input  stream_rev,
`endif
        input  wr_en, wr_addr, shift_en, din, rd_addr, stream_start, stream_ready,
        output rd_data, stream_valid, stream_data, stream_idx, stream_last, busy
    );

endinterface : lpc_regbank_if

`default_nettype wire

// File: rtl/lpc_regbank_stream_ctrl.sv
//------------------------------------------------------------------------------
// Module      : lpc_regbank_stream_ctrl
// Description : Stream FSM, index counter and valid/last generation.
//               LPC_REGBANK_REVERSE_EN enables descending walks via stream_rev.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lpc_regbank_stream_ctrl
    import lpc_regbank_pkg::*;
#(
    parameter int DEPTH  = LPC_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              stream_start,
    input  wire logic              stream_ready,
`ifdef LPC_REGBANK_REVERSE_EN
    input  wire logic              stream_rev,
`endif
    output logic                   stream_valid,
    output logic                   stream_last,
    output logic                   busy,
    output logic [ADDR_W-1:0]      stream_idx
);

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_ONE      = ADDR_W'(1);

    lpc_state_t        r_state;
    lpc_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [ADDR_W-1:0] w_first_idx;
    logic [ADDR_W-1:0] w_step_idx;
    logic              w_at_end;

`ifdef LPC_REGBANK_REVERSE_EN
    // Direction is latched at start so stream_rev may change mid-walk.
    logic r_rev;
    logic w_rev_nxt;

    assign w_first_idx = stream_rev ? c_LAST_IDX : '0;
    assign w_step_idx  = r_rev ? (r_idx - c_ONE) : (r_idx + c_ONE);
    assign w_at_end    = r_rev ? (r_idx == '0) : (r_idx == c_LAST_IDX);
`else
    assign w_first_idx = '0;
    assign w_step_idx  = r_idx + c_ONE;
    assign w_at_end    = (r_idx == c_LAST_IDX);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
`ifdef LPC_REGBANK_REVERSE_EN
            r_rev   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
`ifdef LPC_REGBANK_REVERSE_EN
            r_rev   <= w_rev_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
`ifdef LPC_REGBANK_REVERSE_EN
        w_rev_nxt   = r_rev;
`endif
        case (r_state)
            IDLE: begin
                if (stream_start) begin
                    w_state_nxt = STREAM;
                    w_idx_nxt   = w_first_idx;
`ifdef LPC_REGBANK_REVERSE_EN
                    w_rev_nxt   = stream_rev;
`endif
                end
            end
            STREAM: begin
                // A start coinciding with the final beat is dropped: IDLE is entered first.
                if (stream_ready) begin
                    if (w_at_end) begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt   = w_step_idx;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign busy         = (r_state == STREAM);
    assign stream_valid = (r_state == STREAM);
    assign stream_last  = (r_state == STREAM) && w_at_end;
    assign stream_idx   = r_idx;

endmodule : lpc_regbank_stream_ctrl

`default_nettype wire

// File: rtl/lpc_regbank.sv
//------------------------------------------------------------------------------
// Module      : lpc_regbank
// Description : Parametrised coefficient/history bank with random write,
//               registered read, shift-in delay line and a streaming port.
//               LPC_REGBANK_REVERSE_EN enables reverse-order streaming.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lpc_regbank
    import lpc_regbank_pkg::*;
#(
    parameter int DATA_W = LPC_DATA_W,
    parameter int DEPTH  = LPC_DEPTH,      // must be >= 2
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic     clk,
    input  wire logic     reset,
    lpc_regbank_if.slave  bus
);

    logic [DATA_W-1:0] w_entry [DEPTH];
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_stream_word;
    logic [DATA_W-1:0] r_rd_data;
    logic [ADDR_W-1:0] w_stream_idx;

    // Each entry owns its register; shift beats a random write in the same cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [DATA_W-1:0] r_word;
        logic [DATA_W-1:0] w_shift_src;

        if (gi == 0) begin : g_head
            assign w_shift_src = bus.din;
        end else begin : g_tail
            assign w_shift_src = w_entry[gi-1];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_word <= '0;
            end else if (bus.shift_en) begin
                r_word <= w_shift_src;
            end else if (bus.wr_en && (bus.wr_addr == ADDR_W'(gi))) begin
                r_word <= bus.din;
            end
        end

        assign w_entry[gi] = r_word;
    end

    // Indices at or beyond DEPTH match no entry and therefore read as zero.
    always_comb begin
        w_rd_word     = '0;
        w_stream_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rd_addr == ADDR_W'(i)) begin
                w_rd_word = w_entry[i];
            end
            if (w_stream_idx == ADDR_W'(i)) begin
                w_stream_word = w_entry[i];
            end
        end
    end

    // Sampling pre-edge contents gives old-data on read-during-write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_word;
        end
    end

    lpc_regbank_stream_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_stream_ctrl (
        .clk          (clk),
        .reset        (reset),
        .stream_start (bus.stream_start),
        .stream_ready (bus.stream_ready),
`ifdef LPC_REGBANK_REVERSE_EN
        .stream_rev   (bus.stream_rev),
`endif
        .stream_valid (bus.stream_valid),
        .stream_last  (bus.stream_last),
        .busy         (bus.busy),
        .stream_idx   (w_stream_idx)
    );

    assign bus.rd_data     = r_rd_data;
    assign bus.stream_data = w_stream_word;
    assign bus.stream_idx  = w_stream_idx;

endmodule : lpc_regbank

`default_nettype wire

// File: tb/tb_lpc_regbank.sv
//------------------------------------------------------------------------------
// Module      : tb_lpc_regbank
// Description : Self-checking bench for lpc_regbank (honours LPC_REGBANK_REVERSE_EN).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lpc_regbank;

    localparam int DW    = 32;
    localparam int DEPTH = 9;
    localparam int AW    = $clog2(DEPTH);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    lpc_regbank_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    lpc_regbank #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: bank contents, read pipeline and beat progress.
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_rd;
    logic          m_active;
    int            m_beat;
    logic          m_rev;
    logic          m_init = 1'b0;
    logic          w_rev_in;

`ifdef LPC_REGBANK_REVERSE_EN
    assign w_rev_in = bus.stream_rev;
`else
    assign w_rev_in = 1'b0;
`endif

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
            m_rd     <= '0;
            m_active <= 1'b0;
            m_beat   <= 0;
            m_rev    <= 1'b0;
            m_init   <= 1'b1;
        end else begin
            m_rd <= (int'(bus.rd_addr) < DEPTH) ? m_mem[bus.rd_addr] : '0;
            if (m_active) begin
                if (bus.stream_ready) begin
                    if (m_beat == DEPTH - 1) begin
                        m_active <= 1'b0;
                        m_beat   <= 0;
                    end else begin
                        m_beat <= m_beat + 1;
                    end
                end
            end else if (bus.stream_start) begin
                m_active <= 1'b1;
                m_beat   <= 0;
                m_rev    <= w_rev_in;
            end
            if (bus.shift_en) begin
                for (int i = 1; i < DEPTH; i++) m_mem[i] <= m_mem[i-1];
                m_mem[0] <= bus.din;
            end else if (bus.wr_en && int'(bus.wr_addr) < DEPTH) begin
                m_mem[bus.wr_addr] <= bus.din;
            end
        end
    end

    function automatic int m_idx();
        if (!m_active) return 0;
        return m_rev ? (DEPTH - 1 - m_beat) : m_beat;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    int q_idx[$];
    int q_last[$];

    // Per-cycle comparison against the model, plus beat logging.
    always @(negedge clk) begin
        if (m_init) begin
            check("rd_data", 64'(bus.rd_data), 64'(m_rd));
            check("stream_valid", 64'(bus.stream_valid), 64'(m_active));
            check("busy", 64'(bus.busy), 64'(m_active));
            check("stream_idx", 64'(bus.stream_idx), 64'(m_idx()));
            check("stream_last", 64'(bus.stream_last), 64'(m_active && m_beat == DEPTH - 1));
            if (m_active) check("stream_data", 64'(bus.stream_data), 64'(m_mem[m_idx()]));
            if (bus.stream_valid && bus.stream_ready) begin
                q_idx.push_back(int'(bus.stream_idx));
                q_last.push_back(int'(bus.stream_last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string name, input int addr, input logic [DW-1:0] exp);
        bus.rd_addr = AW'(addr);
        tick();
        check(name, 64'(bus.rd_data), 64'(exp));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) check({name, "_timeout"}, 64'(1), 64'(0));
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.shift_en = 1'b0; bus.din = '0;
        bus.rd_addr = '0; bus.stream_start = 1'b0; bus.stream_ready = 1'b0;
`ifdef LPC_REGBANK_REVERSE_EN
        bus.stream_rev = 1'b0;
`endif
        tick(); tick();
        check("reset_rd_data", 64'(bus.rd_data), 64'(0));
        check("reset_idx", 64'(bus.stream_idx), 64'(0));
        reset = 1'b0;

        // Random write with read-during-write to the same index
        bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.din = 32'hDEADBEEF; bus.rd_addr = 4'd3;
        tick();
        bus.wr_en = 1'b0;
        check("rd_old_on_write", 64'(bus.rd_data), 64'(0));
        tick();
        check("rd_after_write", 64'(bus.rd_data), 64'h00000000DEADBEEF);
        read_check("rd_out_of_range", 9, 32'h0);
        bus.wr_en = 1'b1; bus.wr_addr = 4'd12; bus.din = 32'h12345678;
        tick();
        bus.wr_en = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            read_check("rd_after_oor_write", i, (i == 3) ? 32'hDEADBEEF : 32'h0);

        // Delay-line fill
        for (int k = 1; k <= 10; k++) begin
            bus.shift_en = 1'b1; bus.din = DW'(k);
            tick();
        end
        bus.shift_en = 1'b0;
        read_check("shift_head", 0, 32'd10);
        read_check("shift_tail", 8, 32'd2);
        read_check("shift_mid", 3, 32'd7);

        // Shift has priority over a concurrent write
        bus.shift_en = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.din = 32'h55;
        tick();
        bus.shift_en = 1'b0; bus.wr_en = 1'b0;
        read_check("prio_head", 0, 32'h55);
        read_check("prio_e1", 1, 32'd10);
        read_check("prio_tail", 8, 32'd3);

        // Stream with alternating ready and a stray mid-stream start
        q_idx.delete(); q_last.delete();
        bus.stream_start = 1'b1;
        tick();
        bus.stream_start = 1'b0;
        for (int c = 0; c < 60 && bus.busy; c++) begin
            bus.stream_ready = (c % 2 == 0);
            bus.stream_start = (c == 5);
            tick();
        end
        bus.stream_ready = 1'b0; bus.stream_start = 1'b0;
        check("asc_busy_done", 64'(bus.busy), 64'(0));
        check("asc_beats", 64'(q_idx.size()), 64'(DEPTH));
        for (int i = 0; i < q_idx.size(); i++) begin
            check("asc_idx", 64'(q_idx[i]), 64'(i));
            check("asc_last", 64'(q_last[i]), 64'(i == DEPTH - 1));
        end

        // Start concurrent with the final handshake is dropped
        bus.stream_start = 1'b1;
        tick();
        bus.stream_start = 1'b0; bus.stream_ready = 1'b1;
        for (int n = 0; n < 20 && !bus.stream_last; n++) tick();
        check("reach_last", 64'(bus.stream_last), 64'(1));
        bus.stream_start = 1'b1;
        tick();
        bus.stream_start = 1'b0; bus.stream_ready = 1'b0;
        check("start_on_last_ignored", 64'(bus.busy), 64'(0));

        // Write to the stalled beat, then reset mid-stream
        bus.stream_start = 1'b1;
        tick();
        bus.stream_start = 1'b0;
        tick();
        check("stall_idx0", 64'(bus.stream_idx), 64'(0));
        bus.stream_ready = 1'b1;
        tick(); tick();
        bus.stream_ready = 1'b0;
        check("stall_idx2", 64'(bus.stream_idx), 64'(2));
        bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.din = 32'hCAFEF00D;
        tick();
        bus.wr_en = 1'b0;
        check("stall_write_data", 64'(bus.stream_data), 64'h00000000CAFEF00D);
        check("stall_write_idx", 64'(bus.stream_idx), 64'(2));
        bus.stream_ready = 1'b1;
        tick(); tick();
        bus.stream_ready = 1'b0;
        check("pre_reset_idx", 64'(bus.stream_idx), 64'(4));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_valid", 64'(bus.stream_valid), 64'(0));
        check("abort_idx", 64'(bus.stream_idx), 64'(0));
        check("abort_busy", 64'(bus.busy), 64'(0));
        read_check("abort_e0", 0, 32'h0);
        read_check("abort_e2", 2, 32'h0);

`ifdef LPC_REGBANK_REVERSE_EN
        // Descending walk
        for (int k = 1; k <= DEPTH; k++) begin
            bus.shift_en = 1'b1; bus.din = DW'(k * 16);
            tick();
        end
        bus.shift_en = 1'b0;
        q_idx.delete(); q_last.delete();
        bus.stream_rev = 1'b1; bus.stream_start = 1'b1;
        tick();
        bus.stream_rev = 1'b0; bus.stream_start = 1'b0;
        check("rev_first_data", 64'(bus.stream_data), 64'(16));
        bus.stream_ready = 1'b1;
        drain("rev");
        bus.stream_ready = 1'b0;
        check("rev_beats", 64'(q_idx.size()), 64'(DEPTH));
        for (int i = 0; i < q_idx.size(); i++) begin
            check("rev_idx", 64'(q_idx[i]), 64'(DEPTH - 1 - i));
            check("rev_last", 64'(q_last[i]), 64'(i == DEPTH - 1));
        end
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_lpc_regbank

`default_nettype wire
